// File: rtl/dmem_waitstate.sv
`default_nettype none
// ============================================================================
// Module   : dmem_waitstate
// Purpose  : MEM-stage data memory for the pipelined MIPS core. It has a
//            configurable wait-state handshake, byte/half/word stores,
//            sign/zero-extended sub-word loads and misalignment detection.
//            With WAIT=0 it behaves like a single-cycle memory with a
//            combinational read.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH        number of 32-bit words (power of two)
//   WAIT         wait-state cycles per access (0..15)
// Ports
//   clk          clock
//   reset        asynchronous active-high reset
//   req          access request, held with all request inputs until done
//   we           1 = store, 0 = load
//   size         00 byte, 01 half, 10 word, 11 reserved (handled as word)
//   ld_unsigned  zero-extend sub-word loads
//   addr         byte address; upper bits ignored (wraps modulo DEPTH)
//   wdata        store data, sub-word data in the low bits
//   rdata        extended load data, non-zero only on a completing load
//   done         access completes this cycle
//   stall        req & ~done
//   misalign     completing request was misaligned (no memory effect)
// ============================================================================
module dmem_waitstate #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        stall,
    output logic        misalign
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

    localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WAIT);
    localparam logic [1:0]       C_SIZE_BYTE = 2'b00;
    localparam logic [1:0]       C_SIZE_HALF = 2'b01;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Storage and declarations
    // ------------------------------------------------------------------
    logic [31:0]       r_mem [DEPTH];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    logic              w_fsm_done;
    logic              w_fsm_mis;
    logic              w_commit;

    logic [ADDR_W-1:0] w_idx;
    logic              w_is_byte;
    logic              w_is_half;
    logic              w_is_word;
    logic              w_misaligned;

    logic [31:0]       w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ld_data;
    logic [31:0]       w_wr_word;
    logic [4:0]        w_byte_sh;
    logic [4:0]        w_half_sh;

    // Address bits above the word index are deliberately ignored.
    logic              w_unused_addr;
    assign w_unused_addr = &{1'b0, addr[31:ADDR_W+2]};

    // ------------------------------------------------------------------
    // Address decode and alignment
    // ------------------------------------------------------------------
    assign w_idx     = addr[ADDR_W+1:2];
    assign w_is_byte = (size == C_SIZE_BYTE);
    assign w_is_half = (size == C_SIZE_HALF);
    assign w_is_word = size[1];           // 10 and reserved 11

    assign w_misaligned = (w_is_half & addr[0]) |
                          (w_is_word & (addr[1:0] != 2'b00));

    // Bit offsets of the selected byte / half lane inside the word.
    assign w_byte_sh = {addr[1:0], 3'b000};
    assign w_half_sh = {addr[1], 4'b0000};

    // ------------------------------------------------------------------
    // Load path: combinational read, lane select, extension
    // ------------------------------------------------------------------
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[w_byte_sh +: 8];
    assign w_half = w_word[w_half_sh +: 16];

    always_comb begin
        w_ld_data = w_word;
        if (w_is_byte) begin
            w_ld_data = ld_unsigned ? {24'h000000, w_byte}
                                    : {{24{w_byte[7]}}, w_byte};
        end else if (w_is_half) begin
            w_ld_data = ld_unsigned ? {16'h0000, w_half}
                                    : {{16{w_half[15]}}, w_half};
        end
    end

    // ------------------------------------------------------------------
    // Store path: merge the new lane into the current word so that
    // unselected bits keep their value.
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_word = w_word;
        if (w_is_byte) begin
            w_wr_word[w_byte_sh +: 8] = wdata[7:0];
        end else if (w_is_half) begin
            w_wr_word[w_half_sh +: 16] = wdata[15:0];
        end else begin
            w_wr_word = wdata;
        end
    end

    // ------------------------------------------------------------------
    // Wait-state FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= C_CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Wait-state FSM: next state and completion
    // A misaligned request completes at once and never enters BUSY, so
    // the counter only ever runs for aligned accesses.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fsm_done  = 1'b0;
        w_fsm_mis   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (req) begin
                    if (w_misaligned) begin
                        w_fsm_done = 1'b1;
                        w_fsm_mis  = 1'b1;
                    end else if (WAIT == 0) begin
                        w_fsm_done = 1'b1;
                    end else begin
                        w_state_nxt = ST_BUSY;
                        w_cnt_nxt   = C_CNT_ONE;
                    end
                end
            end
            ST_BUSY: begin
                if (!req) begin
                    // Abort: drop the access without touching memory.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = C_CNT_ZERO;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_fsm_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = C_CNT_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = C_CNT_ZERO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. Reset forces every output low even for the combinational
    // WAIT=0 completion, which also blocks any write during reset.
    // ------------------------------------------------------------------
    assign done     = w_fsm_done & ~reset;
    assign misalign = w_fsm_mis & ~reset;
    assign stall    = req & ~done & ~reset;
    assign rdata    = (done & ~we & ~misalign) ? w_ld_data : 32'h0000_0000;
    assign w_commit = done & we & ~misalign;

    // RAM has no reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_waitstate.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_waitstate
// Purpose  : Self-checking bench for dmem_waitstate. Three instances with
//            WAIT=0, 2 and 3 share the request bus and have separate req.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_waitstate;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
    } exp_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    logic        clk;
    logic        reset;
    logic [2:0]  req_v;
    logic        we;
    logic [1:0]  size;
    logic        ld_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata_w [3];
    logic [2:0]  done_w;
    logic [2:0]  stall_w;
    logic [2:0]  mis_w;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_done_cyc = 0;
    exp_t sb_q[$];
    vec_t vecs[21];

    dmem_waitstate #(.DEPTH(64), .WAIT(0)) u_w0 (
        .clk(clk), .reset(reset), .req(req_v[0]), .we(we), .size(size),
        .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
        .rdata(rdata_w[0]), .done(done_w[0]), .stall(stall_w[0]), .misalign(mis_w[0]));

    dmem_waitstate #(.DEPTH(64), .WAIT(2)) u_w2 (
        .clk(clk), .reset(reset), .req(req_v[1]), .we(we), .size(size),
        .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
        .rdata(rdata_w[1]), .done(done_w[1]), .stall(stall_w[1]), .misalign(mis_w[1]));

    dmem_waitstate #(.DEPTH(64), .WAIT(3)) u_w3 (
        .clk(clk), .reset(reset), .req(req_v[2]), .we(we), .size(size),
        .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
        .rdata(rdata_w[2]), .done(done_w[2]), .stall(stall_w[2]), .misalign(mis_w[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Request inputs must stay stable while an access is pending.
    logic [2:0]  p_req  = '0;
    logic [2:0]  p_done = '0;
    logic        p_rst  = 1'b1;
    logic [68:0] p_in   = '0;
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset && !p_rst && p_req[i] && !p_done[i] && req_v[i]) begin
                assert ({we, size, ld_unsigned, addr, wdata} == p_in)
                    else $error("protocol violation: inputs changed while pending on dut %0d", i);
            end
        end
        p_req  = req_v;
        p_done = done_w;
        p_rst  = reset;
        p_in   = {we, size, ld_unsigned, addr, wdata};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drives one access on instance sel, pushes its expected result and
    // waits (bounded) for done; checks stall while waiting and latency.
    task automatic access(input int sel, input vec_t v, input int lat);
        exp_t e;
        bit   got;
        we          = v.we;
        size        = v.size;
        ld_unsigned = v.uns;
        addr        = v.addr;
        wdata       = v.wdata;
        req_v       = '0;
        req_v[sel]  = 1'b1;
        e.rdata = v.exp_rdata;
        e.mis   = v.exp_mis;
        sb_q.push_back(e);
        got = 1'b0;
        for (int k = 0; k <= lat + 4 && !got; k++) begin
            @(negedge clk);
            if (done_w[sel] === 1'b1) begin
                got = 1'b1;
                last_done_cyc = cyc;
                chk($sformatf("latency dut%0d @%h", sel, v.addr), 32'(k), 32'(lat));
                chk("stall_at_done", {31'b0, stall_w[sel]}, 32'h0);
                e = sb_q.pop_front();
                chk($sformatf("rdata dut%0d @%h", sel, v.addr), rdata_w[sel], e.rdata);
                chk($sformatf("misalign dut%0d @%h", sel, v.addr), {31'b0, mis_w[sel]}, {31'b0, e.mis});
            end else begin
                chk("stall_while_waiting", {31'b0, stall_w[sel]}, 32'h1);
                chk("rdata_while_waiting", rdata_w[sel], 32'h0);
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: dut%0d no done within %0d cycles, expected %0d", sel, lat + 5, lat);
            void'(sb_q.pop_front());
        end
    endtask

    task automatic idle_cycle();
        req_v = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("idle_done", {31'b0, done_w[i]}, 32'h0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string nm);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s done%0d", nm, i), {31'b0, done_w[i]}, 32'h0);
            chk($sformatf("%s stall%0d", nm, i), {31'b0, stall_w[i]}, 32'h0);
            chk($sformatf("%s mis%0d", nm, i), {31'b0, mis_w[i]}, 32'h0);
            chk($sformatf("%s rdata%0d", nm, i), rdata_w[i], 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        // we, size, uns, addr, wdata, exp_rdata, exp_mis
        vecs[0]  = '{1'b1, SZ_W, 1'b0, 32'h08,  32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, SZ_W, 1'b0, 32'h08,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, SZ_W, 1'b0, 32'h10,  32'h11223344, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b1, SZ_H, 1'b0, 32'h12,  32'hFFFF8001, 32'h00000000, 1'b0};
        vecs[4]  = '{1'b0, SZ_H, 1'b0, 32'h12,  32'h0,        32'hFFFF8001, 1'b0};
        vecs[5]  = '{1'b0, SZ_H, 1'b1, 32'h12,  32'h0,        32'h00008001, 1'b0};
        vecs[6]  = '{1'b0, SZ_W, 1'b0, 32'h10,  32'h0,        32'h80013344, 1'b0};
        vecs[7]  = '{1'b1, SZ_W, 1'b0, 32'h20,  32'h55667788, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b1, SZ_B, 1'b0, 32'h23,  32'h1234569A, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b0, SZ_B, 1'b0, 32'h23,  32'h0,        32'hFFFFFF9A, 1'b0};
        vecs[10] = '{1'b0, SZ_B, 1'b1, 32'h23,  32'h0,        32'h0000009A, 1'b0};
        vecs[11] = '{1'b0, SZ_W, 1'b0, 32'h20,  32'h0,        32'h9A667788, 1'b0};
        vecs[12] = '{1'b0, SZ_B, 1'b1, 32'h21,  32'h0,        32'h00000077, 1'b0};
        vecs[13] = '{1'b0, SZ_H, 1'b0, 32'h22,  32'h0,        32'hFFFF9A66, 1'b0};
        vecs[14] = '{1'b1, SZ_H, 1'b0, 32'h09,  32'h00000000, 32'h00000000, 1'b1};
        vecs[15] = '{1'b1, SZ_W, 1'b0, 32'h0A,  32'h00000000, 32'h00000000, 1'b1};
        vecs[16] = '{1'b0, SZ_W, 1'b0, 32'h08,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[17] = '{1'b0, SZ_W, 1'b0, 32'h108, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[18] = '{1'b0, SZ_R, 1'b0, 32'h08,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[19] = '{1'b0, SZ_W, 1'b0, 32'h06,  32'h0,        32'h00000000, 1'b1};
        vecs[20] = '{1'b0, SZ_W, 1'b1, 32'h08,  32'h0,        32'hDEADBEEF, 1'b0};

        // Reset with an aligned load requested on every instance.
        reset = 1'b1;
        req_v = 3'b111;
        we = 1'b0; size = SZ_W; ld_unsigned = 1'b0; addr = 32'h8; wdata = '0;
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_v = '0;
        @(posedge clk);
        #1;

        // WAIT=0 table, issued back to back.
        for (int i = 0; i < 21; i++) begin
            access(0, vecs[i], 0);
        end
        idle_cycle();

        // WAIT=2: store, then two held loads back to back: done at t+2, t+5.
        access(1, '{1'b1, SZ_W, 1'b0, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0}, 2);
        idle_cycle();
        c0 = cyc;
        access(1, '{1'b0, SZ_W, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0}, 2);
        chk("b2b_first_done_cycle", 32'(last_done_cyc - c0), 32'd2);
        access(1, '{1'b0, SZ_H, 1'b1, 32'h42, 32'h0, 32'h0000CAFE, 1'b0}, 2);
        chk("b2b_second_done_cycle", 32'(last_done_cyc - c0), 32'd5);
        idle_cycle();

        // WAIT=3: misaligned requests complete immediately, memory intact.
        access(2, '{1'b1, SZ_W, 1'b0, 32'h04, 32'h01020304, 32'h0, 1'b0}, 3);
        access(2, '{1'b1, SZ_H, 1'b0, 32'h05, 32'hFFFFFFFF, 32'h0, 1'b1}, 0);
        access(2, '{1'b0, SZ_W, 1'b0, 32'h06, 32'h0,        32'h0, 1'b1}, 0);
        access(2, '{1'b0, SZ_W, 1'b0, 32'h04, 32'h0, 32'h01020304, 1'b0}, 3);
        idle_cycle();

        // WAIT=3 abort: store dropped after two cycles, no write.
        we = 1'b1; size = SZ_W; ld_unsigned = 1'b0; addr = 32'h4; wdata = 32'h55555555;
        req_v = 3'b100;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        idle_cycle();
        access(2, '{1'b0, SZ_W, 1'b0, 32'h04, 32'h0, 32'h01020304, 1'b0}, 3);
        idle_cycle();

        // WAIT=3 store hit by reset at cnt=2: discarded, outputs quiet.
        we = 1'b1; size = SZ_W; ld_unsigned = 1'b0; addr = 32'h4; wdata = 32'hAAAAAAAA;
        req_v = 3'b100;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check_quiet("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_v = '0;
        idle_cycle();
        access(2, '{1'b0, SZ_W, 1'b0, 32'h04, 32'h0, 32'h01020304, 1'b0}, 3);
        // RAM of the WAIT=0 instance survived the reset pulse.
        access(0, '{1'b0, SZ_W, 1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0}, 0);
        idle_cycle();

        // Held load across reset restarts the full WAIT count.
        we = 1'b0; size = SZ_B; ld_unsigned = 1'b1; addr = 32'h7; wdata = '0;
        req_v = 3'b100;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        access(2, '{1'b0, SZ_B, 1'b1, 32'h07, 32'h0, 32'h00000001, 1'b0}, 3);
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_waitstate.md
Name: dmem_waitstate

Overview:
- Parametrised next-generation data memory for the pipelined MIPS core.
- Adds a configurable wait-state handshake: `stall` freezes the pipeline and `done` marks completion.
- Handles byte/half/word stores and sign/zero-extended loads internally, replacing the separate store-lane and load-extension logic.
- Adds misalignment detection.
- Sits in the MEM stage; with WAIT=0 its timing matches a single-cycle combinational-read data memory.

Parameters:
- DEPTH, 64, number of 32-bit words; ADDR_W = clog2(DEPTH).
- WAIT, 0, wait-state cycles per access (0..15).

Ports:
- clk  input  1  clock
- reset  input  1  reset
- req  input  1  access request; held with all request inputs until done
- we  input  1  1 = store, 0 = load
- size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- ld_unsigned  input  1  zero-extend sub-word loads (lbu/lhu)
- addr  input  32  byte address
- wdata  input  32  store data; sub-word data in the low bits
- rdata  output  32  extended load data; valid when done=1 and we=0
- done  output  1  access completes this cycle
- stall  output  1  req & ~done; the pipeline holds while high
- misalign  output  1  current request is misaligned (valid with done)

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- While reset is asserted:
  - FSM goes to IDLE and the wait counter clears to 0.
  - done, stall, misalign and rdata are all 0.
  - RAM contents are not cleared.
- Word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so accesses wrap modulo DEPTH.
- Alignment check (combinational):
  - half is misaligned when addr[0]=1.
  - word/reserved is misaligned when addr[1:0]≠0.
  - byte is always aligned.
- FSM states are IDLE and BUSY, with counter cnt of width max(1, clog2(WAIT+1)).
- IDLE, req=0: done=0, stall=0.
- IDLE, req=1 and misaligned:
  - done=1 and misalign=1 in the same cycle, regardless of WAIT.
  - No write; rdata=0; stay in IDLE.
- IDLE, req=1, aligned, WAIT=0: done=1 combinationally; a store commits at the closing edge; stay in IDLE.
- IDLE, req=1, aligned, WAIT>0: done=0, stall=1; at the edge go to BUSY with cnt=1.
- BUSY, req=1, cnt<WAIT: done=0; cnt increments.
- BUSY, req=1, cnt=WAIT:
  - done=1.
  - A store commits at the closing edge.
  - Return to IDLE.
- BUSY, req=0 (abort): return to IDLE and clear cnt; no write.
- Latency: a request first presented in cycle t completes (done=1) in cycle t+WAIT.
- Back-to-back requests:
  - A request still high in the cycle after done is a new access.
  - No bubble is inserted beyond the WAIT cycles.
- Store lanes:
  - byte writes wdata[7:0] into bits [8*addr[1:0] +: 8].
  - half writes wdata[15:0] into bits [16*addr[1] +: 16].
  - word writes all 32 bits.
  - Unselected bits are unchanged.
- Load path:
  - The RAM word is read combinationally and the lane is selected as for stores.
  - Sub-word data is sign-extended unless ld_unsigned=1, in which case it is zero-extended.
  - ld_unsigned is ignored for word loads.
- rdata is 0 whenever done=0 or we=1.
- Reset mid-access: the pending store is discarded and the FSM returns to IDLE. After reset deasserts, a held req restarts the full WAIT count.
- Request inputs that change while in BUSY with req=1 are a protocol violation; behaviour is undefined, and the bench asserts against it.

Test Plan:
- WAIT=0: store word 0xDEADBEEF to 0x8, then load word from 0x8 → rdata=0xDEADBEEF, done=1, stall=0 in the load cycle.
- WAIT=0: store half 0x8001 to 0x12, then load half from 0x12 → 0xFFFF8001; lhu → 0x00008001; word at 0x10 = 0x8001xxxx with low half unchanged.
- WAIT=0: store byte 0x9A to 0x23, then lb → 0xFFFFFF9A, lbu → 0x0000009A; other bytes of word 0x20 unchanged.
- WAIT=2: load held from cycle t → stall=1 for cycles t and t+1, done=1 in t+2; a second held request completes in t+5.
- Misaligned: half at 0x5, word at 0x6 → done=1 and misalign=1 immediately with WAIT=3; memory unchanged; rdata=0.
- WAIT=3 store: assert reset at cnt=2 (or drop req) → no write; a subsequent load returns the old value; done/stall are 0 during reset.
